// File: rtl/idma_legalizer_burst_splitter.sv
// Splits a 1D transfer (address, byte length) into bursts that never cross a
// virtual page whose width depends on bursting mode, user beat limit and a page cap.
module idma_legalizer_burst_splitter #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned LenWidth      = 32,
  parameter int unsigned OffsetWidth   = 2,
  parameter int unsigned MaxBeatsLog2  = 8,
  parameter int unsigned PageCapWidth  = 12,
  parameter int unsigned BurstLenWidth = PageCapWidth + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [AddrWidth-1:0]     req_addr_i,
  input  logic [LenWidth-1:0]      req_len_i,
  input  logic                     not_bursting_i,
  input  logic                     reduce_len_i,
  input  logic [2:0]               max_llen_i,
  output logic                     burst_valid_o,
  input  logic                     burst_ready_i,
  output logic [AddrWidth-1:0]     burst_addr_o,
  output logic [BurstLenWidth-1:0] burst_len_o,
  output logic                     burst_last_o,
  output logic                     busy_o
);

  localparam int unsigned CmpWidth = (LenWidth > BurstLenWidth) ? LenWidth : BurstLenWidth;

  typedef enum logic {IDLE, SPLIT} state_e;

  state_e                   state_q, state_d;
  logic [3:0]               w_q, cfg_w, src_w;
  logic [4:0]               w_sum;
  logic [AddrWidth-1:0]     burst_addr_q, nxt_addr_q, src_addr, calc_next_addr;
  logic [LenWidth-1:0]      rem_q, src_rem, calc_rem;
  logic [BurstLenWidth-1:0] burst_len_q, page_size, page_off, to_pb, calc_len;
  logic                     burst_last_q, calc_last;
  logic                     burst_hs, req_hs, load_new, load_next;

  always_comb begin
    w_sum = 5'(OffsetWidth) + (reduce_len_i ? 5'(max_llen_i) : 5'(MaxBeatsLog2));
    if (not_bursting_i)                 cfg_w = 4'(OffsetWidth);
    else if (w_sum > 5'(PageCapWidth))  cfg_w = 4'(PageCapWidth);
    else                                cfg_w = w_sum[3:0];
  end

  // Ready is gated by reset so every output reads 0 while rst_i is held.
  assign burst_hs    = (state_q == SPLIT) && burst_ready_i;
  assign req_ready_o = !rst_i && ((state_q == IDLE) || (burst_hs && burst_last_q));
  assign req_hs      = req_valid_i && req_ready_o;
  assign load_new    = req_hs && (req_len_i != '0);
  assign load_next   = burst_hs && !burst_last_q;

  // One burst calculator shared by a new request and the continuation of the current one.
  always_comb begin
    src_addr       = load_new ? req_addr_i : nxt_addr_q;
    src_rem        = load_new ? req_len_i  : rem_q;
    src_w          = load_new ? cfg_w      : w_q;
    page_size      = BurstLenWidth'(1) << src_w;
    page_off       = BurstLenWidth'(src_addr & AddrWidth'(page_size - BurstLenWidth'(1)));
    to_pb          = page_size - page_off;
    calc_len       = (CmpWidth'(src_rem) < CmpWidth'(to_pb)) ? BurstLenWidth'(src_rem) : to_pb;
    calc_last      = (CmpWidth'(src_rem) == CmpWidth'(calc_len));
    calc_rem       = src_rem - LenWidth'(calc_len);
    calc_next_addr = src_addr + AddrWidth'(calc_len);
  end

  always_comb begin
    state_d = state_q;
    if (load_new)                      state_d = SPLIT;
    else if (burst_hs && burst_last_q) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      w_q          <= '0;
      burst_addr_q <= '0;
      burst_len_q  <= '0;
      burst_last_q <= 1'b0;
      nxt_addr_q   <= '0;
      rem_q        <= '0;
    end else begin
      state_q <= state_d;
      if (load_new) w_q <= cfg_w;
      if (load_new || load_next) begin
        burst_addr_q <= src_addr;
        burst_len_q  <= calc_len;
        burst_last_q <= calc_last;
        nxt_addr_q   <= calc_next_addr;
        rem_q        <= calc_rem;
      end
    end
  end

  assign burst_valid_o = (state_q == SPLIT);
  assign busy_o        = (state_q == SPLIT);
  assign burst_addr_o  = burst_addr_q;
  assign burst_len_o   = burst_len_q;
  assign burst_last_o  = burst_last_q;

endmodule
